// File: rtl/db_pkg.sv
// Shared definitions for the switch debouncer: FSM state encodings and
// default timing constants.
package db_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } db_state_t;

   // 1 ms of stability at a 50 MHz clock.
   localparam int DEFAULT_STABLE_CYCLES = 50000;
   localparam int DEFAULT_CNT_W         = 16;

   localparam int PRESS_W = 8;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module bit_sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a raw switch level: a new level is accepted only after
// STABLE_CYCLES consecutive identical synchronized samples.
module switch_debouncer
   import db_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int CNT_W         = DEFAULT_CNT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sw_in,
   input  logic               count_clear,
   output logic               sw_level,
   output logic               rise_pulse,
   output logic               fall_pulse,
   output logic [PRESS_W-1:0] press_count
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic sw_sync;

   db_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               level_q, level_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic [PRESS_W-1:0] press_q, press_d;

   bit_sync2 u_sw_sync (
      .clock (clock),
      .reset (reset),
      .d     (sw_in),
      .q     (sw_sync)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         press_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         press_q <= press_d;
      end
   end

   // The entering sample counts as the first, so acceptance happens on the
   // sample that finds the counter already at STABLE_CYCLES-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LOW: begin
            cnt_d = '0;
            if (sw_sync) begin
               state_d = PEND_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         PEND_HIGH: begin
            if (!sw_sync) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            cnt_d = '0;
            if (!sw_sync) begin
               state_d = PEND_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         PEND_LOW: begin
            if (sw_sync) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // Counts the registered rise pulse; a clear in the same cycle wins.
   always_comb begin
      press_d = press_q;
      if (count_clear) begin
         press_d = '0;
      end else if (rise_q) begin
         press_d = press_q + PRESS_W'(1);
      end
   end

   assign sw_level    = level_q;
   assign rise_pulse  = rise_q;
   assign fall_pulse  = fall_q;
   assign press_count = press_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with STABLE_CYCLES=4: stimulus queues
// expected pulses, a negedge monitor pops and compares them.
module tb_switch_debouncer;

   localparam int SC  = 4;
   localparam int LAT = SC + 2;

   logic       clock;
   logic       reset;
   logic       sw_in;
   logic       count_clear;
   logic       sw_level;
   logic       rise_pulse;
   logic       fall_pulse;
   logic [7:0] press_count;

   typedef struct {
      bit is_fall;
      int edge_no;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   edge_cnt;
   int   passed;
   int   total;

   switch_debouncer #(
      .STABLE_CYCLES (SC),
      .CNT_W         (3)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sw_in       (sw_in),
      .count_clear (count_clear),
      .sw_level    (sw_level),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .press_count (press_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d, required %0d (time %0t)", name, act, req, $time);
      end
   endtask

   // Drive a new switch level just after a clock edge; the accepted edge
   // follows LAT edges later.
   task automatic drive_level(input logic v, input bit expect_evt);
      exp_t e;
      @(posedge clock);
      #1;
      sw_in = v;
      if (expect_evt) begin
         e.is_fall = !v;
         e.edge_no = edge_cnt + LAT;
         exp_q.push_back(e);
      end
      $display("drive sw_in=%0d after edge %0d expect_event=%0d", v, edge_cnt, expect_evt);
   endtask

   task automatic press_release();
      drive_level(1'b1, 1'b1);
      repeat (8) @(posedge clock);
      drive_level(1'b0, 1'b1);
      repeat (8) @(posedge clock);
   endtask

   // Monitor: every pulse must match the head of the expected queue.
   always @(negedge clock) begin
      if (!reset) begin
         check("pulse_overlap", int'(rise_pulse & fall_pulse), 0);
         if (rise_pulse || fall_pulse) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse_queue_size", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               check("pulse_kind_fall", int'(fall_pulse), int'(mon_e.is_fall));
               check("pulse_edge", edge_cnt, mon_e.edge_no);
               check("level_at_pulse", int'(sw_level), int'(!mon_e.is_fall));
               $display("pulse %s at edge %0d level=%0d count=%0d",
                        fall_pulse ? "fall" : "rise", edge_cnt, sw_level, press_count);
            end
         end
      end
   end

   initial begin
      passed      = 0;
      total       = 0;
      reset       = 1'b1;
      sw_in       = 1'b0;
      count_clear = 1'b0;

      #12;
      check("reset_level", int'(sw_level), 0);
      check("reset_rise", int'(rise_pulse), 0);
      check("reset_fall", int'(fall_pulse), 0);
      check("reset_count", int'(press_count), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Hold high until accepted, then hold low until accepted.
      drive_level(1'b1, 1'b1);
      repeat (8) @(posedge clock);
      #1;
      check("level_after_rise", int'(sw_level), 1);
      check("count_after_rise", int'(press_count), 1);
      drive_level(1'b0, 1'b1);
      repeat (8) @(posedge clock);
      #1;
      check("level_after_fall", int'(sw_level), 0);
      check("count_after_fall", int'(press_count), 1);

      count_clear = 1'b1;
      @(posedge clock);
      #1;
      count_clear = 1'b0;
      check("count_after_clear", int'(press_count), 0);

      // Bounces shorter than STABLE_CYCLES must be rejected.
      drive_level(1'b1, 1'b0);
      repeat (2) @(posedge clock);
      drive_level(1'b0, 1'b0);
      drive_level(1'b1, 1'b0);
      repeat (2) @(posedge clock);
      drive_level(1'b0, 1'b0);
      repeat (10) @(posedge clock);
      #1;
      check("bounce_level", int'(sw_level), 0);
      check("bounce_count", int'(press_count), 0);

      // Wrap of the press counter.
      for (int i = 0; i < 255; i++) press_release();
      #1;
      check("count_255", int'(press_count), 255);
      press_release();
      #1;
      check("count_wrap", int'(press_count), 0);

      press_release();
      press_release();
      #1;
      check("count_two", int'(press_count), 2);
      drive_level(1'b1, 1'b1);
      repeat (LAT) @(posedge clock);
      #1;
      check("rise_cycle_for_clear", int'(rise_pulse), 1);
      count_clear = 1'b1;
      @(posedge clock);
      #1;
      count_clear = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("clear_beats_increment", int'(press_count), 0);

      // Asynchronous reset while the level is high: no fall pulse.
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_level", int'(sw_level), 0);
      check("async_reset_rise", int'(rise_pulse), 0);
      check("async_reset_fall", int'(fall_pulse), 0);
      check("async_reset_count", int'(press_count), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      begin
         exp_t e;
         e.is_fall = 1'b0;
         e.edge_no = edge_cnt + LAT;
         exp_q.push_back(e);
      end
      $display("reset released after edge %0d with sw_in=1", edge_cnt);
      repeat (10) @(posedge clock);
      #1;
      check("level_after_reset_rise", int'(sw_level), 1);
      check("count_after_reset_rise", int'(press_count), 1);

      check("pending_events", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL take parameter STABLE_CYCLES, default 50000, meaning the number of consecutive synchronized samples needed to accept a new level (1 ms at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL take parameter CNT_W, default 16, meaning the width of the internal stability counter; CNT_W SHALL satisfy 2**CNT_W > STABLE_CYCLES.
REQ-003 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: the asynchronous, active-high reset.
REQ-005 Port sw_in, input, 1 bit: raw, bouncing, asynchronous switch or key level.
REQ-006 Port count_clear, input, 1 bit: synchronous clear of press_count.
REQ-007 Port sw_level, output, 1 bit: clean debounced level; this is the data source for downstream flip-flop stages.
REQ-008 Port rise_pulse, output, 1 bit: one-cycle pulse when sw_level goes 0->1.
REQ-009 Port fall_pulse, output, 1 bit: one-cycle pulse when sw_level goes 1->0.
REQ-010 Port press_count, output, 8 bits: number of accepted rising edges.

Function
REQ-011 sw_in SHALL pass through a 2-flop synchronizer; sw_sync is the output of the second flop.
REQ-012 The FSM SHALL have exactly four states: STABLE_LOW, PEND_HIGH, STABLE_HIGH and PEND_LOW.
REQ-013 In STABLE_LOW with sw_sync=1, the FSM SHALL go to PEND_HIGH with the counter loaded to 1; with sw_sync=0 it SHALL stay in STABLE_LOW.
REQ-014 In PEND_HIGH with sw_sync=0, the FSM SHALL return to STABLE_LOW (bounce rejected, counter cleared, no pulse).
REQ-015 In PEND_HIGH with sw_sync=1 and counter < STABLE_CYCLES-1, the counter SHALL increment.
REQ-016 In PEND_HIGH with sw_sync=1 and counter = STABLE_CYCLES-1, the FSM SHALL go to STABLE_HIGH and register sw_level=1 and rise_pulse=1 at the same edge.
REQ-017 STABLE_HIGH and PEND_LOW SHALL behave symmetrically to REQ-013..016 with levels inverted; acceptance SHALL drive sw_level=0 and fall_pulse=1.
REQ-018 Latency: if sw_in is high at clock edges k through k+STABLE_CYCLES+1, sw_level SHALL first read 1 after edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges counting edge k; the falling direction SHALL have the same latency.
REQ-019 rise_pulse and fall_pulse SHALL each be high for exactly one cycle per accepted transition and SHALL never be high in the same cycle.
REQ-020 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-021 press_count SHALL increment by 1 on each cycle in which rise_pulse is registered high, wrapping from 255 to 0.
REQ-022 count_clear=1 SHALL set press_count to 0 at the next edge; if it coincides with an increment, the clear SHALL win and the result SHALL be 0.
REQ-023 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL be held at 0 in the STABLE states.

Reset
REQ-024 While reset=1, independent of clock: the sync flops SHALL be 0, the state STABLE_LOW, the counter 0, sw_level 0, rise_pulse 0, fall_pulse 0 and press_count 0.
REQ-025 Reset asserted while sw_level=1 SHALL force sw_level to 0 without producing a fall_pulse.
REQ-026 Reset asserted during PEND_* SHALL abandon the pending transition.
REQ-027 After reset deasserts with sw_in held high, a full debounce SHALL be required: rise after STABLE_CYCLES+2 edges.

Structure
REQ-028 Package db_pkg SHALL hold the 2-bit state encodings (STABLE_LOW=0, PEND_HIGH=1, STABLE_HIGH=2, PEND_LOW=3) and the default STABLE_CYCLES constant.
REQ-029 The synchronizer SHALL be a sub-module named bit_sync2 with ports clock, reset, d and q, reset to 0, and reused for other asynchronous inputs.
REQ-030 The FSM, counter and press_count SHALL live in switch_debouncer; the block SHALL use no latches and no derived clocks.

Verification (bench parameter STABLE_CYCLES=4)
REQ-031 Hold sw_in=1 from edge 0 after reset -> sw_level=1 and rise_pulse=1 after edge 5, rise_pulse=0 after edge 6, press_count=1.
REQ-032 sw_in=1 for 3 cycles, then 0, then 1 for 3, then 0 -> sw_level stays 0, no pulses, press_count=0.
REQ-033 Hold high until accepted, then hold low -> fall_pulse exactly once, 6 edges after the low starts; sw_level=0.
REQ-034 Make 256 accepted presses -> press_count=0 (wrap); then 3 presses with count_clear asserted on the third rise_pulse cycle -> press_count=0.
REQ-035 Assert reset asynchronously mid-cycle while sw_level=1 -> all outputs 0 immediately, no fall_pulse; after release with sw_in=1, rise after 6 edges.
